// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit sequencer state type and the line idle level. The receive
// block will import the same package.
package uart_pkg;

  // Transmit sequencer states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Level of the serial line between frames and during stop bits
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter for the UART transmitter.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   load     in  reload strobe, asserted on entry to every bit
//   load_val in  value to reload (bit period minus one)
//   bit_end  out high in the last cycle of the current bit period
// After a load the counter holds load_val and then decrements once per clock.
// bit_end is high while it holds zero, so a bit lasts load_val+1 cycles.
// Issuing load in the bit_end cycle starts the next bit without any gap.
module uart_baud_cnt #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer.
// Pops bytes from the TX FIFO and serialises them onto txd as frames made of a
// start bit, data bits (LSB first), an optional parity bit and one or two stop
// bits.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   tx_en         allows new frames to start (level)
//   baud_div      bit period is baud_div+1 clocks
//   parity_en     append a parity bit
//   parity_odd    1: odd parity, 0: even parity
//   stop2         two stop bits instead of one
//   fifo_empty    TX FIFO empty flag
//   fifo_rd_data  TX FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    TX FIFO pop strobe
//   txd           serial output, registered, idle high
//   busy          high whenever a frame is being fetched or sent
//   frame_done    pulse in the last cycle of the final stop bit
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  tx_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  txd_q, txd_d;

  logic                  cnt_load;
  logic [DIV_WIDTH-1:0]  cnt_val;
  logic                  bit_end;

  uart_baud_cnt #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .bit_end  (bit_end)
  );

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    cnt_load   = 1'b0;
    cnt_val    = div_q;

    unique case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        // Frame configuration is frozen here for the whole frame.
        shift_d    = fifo_rd_data;
        div_d      = baud_div;
        par_en_d   = parity_en;
        stop2_d    = stop2;
        par_bit_d  = (^fifo_rd_data) ^ parity_odd;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
        // div_q is not yet updated, so the first bit uses the live input.
        cnt_load   = 1'b1;
        cnt_val    = baud_div;
        state_d    = START;
      end

      START: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          shift_d  = shift_q >> 1;
          if (bit_idx_q == LastIdx) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          state_d  = STOP;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            cnt_load   = 1'b1;
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = (tx_en && !fifo_empty) ? FETCH : IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so that txd_q changes exactly on
  // bit boundaries and is never combinationally decoded.
  always_comb begin
    txd_d = IDLE_LEVEL;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_bit_d;
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
    end
  end

  assign txd        = txd_q;
  assign fifo_rd_en = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && bit_end && (!stop2_q || stop_cnt_q);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl.
// A FIFO model answers pops; every pop schedules the expected txd, busy and
// frame_done waveform on an absolute cycle timeline built from the frame
// format, and every cycle the outputs are compared against that timeline.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_en, txd, busy, frame_done;

  uart_tx_ctrl #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .baud_div     (baud_div),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .stop2        (stop2),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .txd          (txd),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int last_pop_cyc = 0;
  int last_done_cyc = 0;
  int fall_cyc = 0;
  int pop_cyc_q[$];
  logic [7:0] fifo_q[$];
  bit exp_txd[int];
  bit exp_busy[int];
  bit exp_done[int];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Expected frame popped at cycle f: FETCH at f, LOAD at f+1, start bit at f+2.
  task automatic plan_frame(input int f, input logic [7:0] data);
    bit bits[$];
    int per, len;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (parity_en) bits.push_back((^data) ^ parity_odd);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    per = int'(baud_div) + 1;
    len = bits.size() * per;
    for (int k = 0; k < len; k++) exp_txd[f + 2 + k] = bits[k / per];
    for (int c = f; c <= f + 1 + len; c++) exp_busy[c] = 1'b1;
    exp_done[f + 1 + len] = 1'b1;
  endtask

  // FIFO model and per-cycle output monitor
  always @(negedge clk) begin : mon
    logic [7:0] d;
    bit e_txd, e_busy, e_done;
    cyc++;
    if (rst_n) begin
      if (fifo_rd_en) begin
        check_eq("pop_nonempty", 32'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) begin
          d = fifo_q.pop_front();
          fifo_rd_data = d;
          plan_frame(cyc, d);
        end
        pop_cnt++;
        last_pop_cyc = cyc;
        pop_cyc_q.push_back(cyc);
      end
      e_txd  = exp_txd.exists(cyc) ? exp_txd[cyc] : 1'b1;
      e_busy = exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0;
      e_done = exp_done.exists(cyc) ? exp_done[cyc] : 1'b0;
      check_eq("txd", 32'(txd), 32'(e_txd));
      check_eq("busy", 32'(busy), 32'(e_busy));
      check_eq("frame_done", 32'(frame_done), 32'(e_done));
      if (frame_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
    if (fifo_empty && fifo_q.size() != 0) fall_cyc = cyc;
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      #1;
      if (fifo_q.size() == 0 && !busy) break;
    end
    check_eq("idle_reached", {30'd0, fifo_q.size() != 0, busy}, 0);
    #1;
  endtask

  task automatic wait_pop(input int base, input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      #1;
      if (pop_cnt > base) break;
    end
    check_eq("pop_seen", 32'(pop_cnt > base), 1);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_txd"}, 32'(txd), 1);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    check_eq({tag, "_done"}, 32'(frame_done), 0);
  endtask

  initial begin : main
    int p0, d0, nb;
    // Reset state
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Directed: 0xA5, 4 cycles per bit, 8N1
    step(2);
    tx_en = 1'b1;
    push(8'hA5);
    wait_idle(200);
    check_eq("t1_pops", pop_cnt, 1);
    check_eq("t1_dones", done_cnt, 1);
    check_eq("t1_fetch_latency", last_pop_cyc - fall_cyc, 1);
    check_eq("t1_frame_len", last_done_cyc - last_pop_cyc, 1 + 40);

    // Parity even, odd, then two stop bits
    baud_div = 16'd2; parity_en = 1'b1; parity_odd = 1'b0;
    step(1); push(8'h07); wait_idle(200);
    check_eq("t2_even_len", last_done_cyc - last_pop_cyc, 1 + 11 * 3);
    parity_odd = 1'b1;
    step(1); push(8'h07); wait_idle(200);
    stop2 = 1'b1;
    step(1); push(8'h07); wait_idle(200);
    check_eq("t2_stop2_len", last_done_cyc - last_pop_cyc, 1 + 12 * 3);

    // Back-to-back frames
    baud_div = 16'd1; parity_en = 1'b0; stop2 = 1'b0;
    step(1);
    pop_cyc_q.delete();
    push(8'h3C); push(8'hC3);
    wait_idle(200);
    check_eq("t3_pop_count", pop_cyc_q.size(), 2);
    if (pop_cyc_q.size() == 2) check_eq("t3_gap", pop_cyc_q[1] - pop_cyc_q[0], 2 + 20);

    // tx_en low holds off; dropping it mid-frame finishes only that frame
    tx_en = 1'b0;
    p0 = pop_cnt;
    step(1); push(8'h5A); push(8'h81);
    step(20);
    check_eq("t4_no_pop", pop_cnt, p0);
    check_eq("t4_txd_idle", 32'(txd), 1);
    check_eq("t4_not_busy", 32'(busy), 0);
    tx_en = 1'b1;
    wait_pop(p0, 50);
    step(5);
    tx_en = 1'b0;
    step(60);
    check_eq("t4_one_pop", pop_cnt, p0 + 1);
    check_eq("t4_idle_after", 32'(busy), 0);
    check_eq("t4_left_in_fifo", fifo_q.size(), 1);
    tx_en = 1'b1;
    wait_idle(200);

    // Reset during data bits
    baud_div = 16'd3;
    p0 = pop_cnt;
    step(1); push(8'h96);
    wait_pop(p0, 50);
    repeat (9) @(negedge clk);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t5_mid_reset");
    exp_txd.delete(); exp_busy.delete(); exp_done.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1); push(8'h4B); wait_idle(200);
    check_eq("t5_after_reset_done", done_cnt, d0 + 1);
    check_eq("t5_after_reset_len", last_done_cyc - last_pop_cyc, 1 + 40);

    // Minimum bit period, then an empty FIFO
    baud_div = 16'd0;
    step(1); push(8'hFF); wait_idle(100);
    check_eq("t6_len", last_done_cyc - last_pop_cyc, 1 + 10);
    p0 = pop_cnt;
    step(30);
    check_eq("t6_empty_no_pop", pop_cnt, p0);
    check_eq("t6_empty_idle", 32'(busy), 0);

    // Randomized frames, sometimes with config changed mid-frame
    for (int it = 0; it < 25; it++) begin
      baud_div   = 16'($urandom_range(0, 4));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2      = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      p0 = pop_cnt;
      step(1);
      for (int b = 0; b < nb; b++) push(8'($urandom));
      if (nb == 1 && $urandom_range(0, 1) == 1) begin
        wait_pop(p0, 50);
        step(3);
        baud_div   = 16'($urandom_range(0, 4));
        parity_en  = ~parity_en;
        parity_odd = 1'($urandom_range(0, 1));
        stop2      = ~stop2;
      end
      wait_idle(2000);
      check_eq("rand_pops", pop_cnt - p0, nb);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d bad=%0d", n_checks, n_bad);
    $fatal(1);
  end

endmodule
